// File: rtl/controller.sv
// controller -- main instruction decoder for the five-stage MIPS pipeline.
//
// Decodes Op (instruction[31:26]) and func (instruction[5:0]) into datapath
// control signals. Decode is purely combinational. A one-bit qualification
// flag (en) forces every output to zero from reset assertion until the first
// rising clock edge after reset is released. This keeps a stale store or
// write-back from firing during reset recovery.
//
// Ports:
//   clk      in   1  rising-edge clock (only used to arm en)
//   reset    in   1  asynchronous, active-low reset
//   Op       in   6  opcode field
//   func     in   6  R-type function field
//   RegDst   out  2  0=rt, 1=rd, 2=$31
//   ALUSrc   out  1  0=rt register, 1=extended immediate
//   ALUCtrl  out  3  000 add, 001 sub, 010 or, 011 pass B
//   ExtOp    out  2  0=zero-ext, 1=sign-ext, 2=imm<<16
//   MemtoReg out  1  write-back takes the loaded word (lw)
//   lwl      out  1  write-back takes the lwl merge result
//   RegWrite out  1  register file write enable
//   MemWrite out  1  data memory write enable
//   Branch   out  1  beq
//   Jump     out  1  j / jal
//   JumpReg  out  1  jr
//   Link     out  1  write-back value is PC+8 (jal)
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] func,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [2:0] ALUCtrl,
  output logic [1:0] ExtOp,
  output logic       MemtoReg,
  output logic       lwl,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic       JumpReg,
  output logic       Link
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_ORI   = 6'b001101,
    OP_LUI   = 6'b001111,
    OP_LWL   = 6'b100010,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR   = 6'b001000,
    FN_ADDU = 6'b100001,
    FN_SUBU = 6'b100011
  } funct_e;

  logic en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) en <= 1'b0;
    else        en <= 1'b1;
  end

  always_comb begin
    RegDst   = '0;
    ALUSrc   = 1'b0;
    ALUCtrl  = '0;
    ExtOp    = '0;
    MemtoReg = 1'b0;
    lwl      = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    JumpReg  = 1'b0;
    Link     = 1'b0;
    if (en) begin
      case (Op)
        OP_RTYPE: begin
          case (func)
            FN_ADDU: begin
              RegDst   = 2'd1;
              ALUCtrl  = 3'b000;
              RegWrite = 1'b1;
            end
            FN_SUBU: begin
              RegDst   = 2'd1;
              ALUCtrl  = 3'b001;
              RegWrite = 1'b1;
            end
            FN_JR: JumpReg = 1'b1;
            default: ;
          endcase
        end
        OP_ORI: begin
          ALUSrc   = 1'b1;
          ExtOp    = 2'd0;
          ALUCtrl  = 3'b010;
          RegWrite = 1'b1;
        end
        OP_LUI: begin
          ALUSrc   = 1'b1;
          ExtOp    = 2'd2;
          ALUCtrl  = 3'b011;
          RegWrite = 1'b1;
        end
        OP_LW: begin
          ALUSrc   = 1'b1;
          ExtOp    = 2'd1;
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        OP_LWL: begin
          ALUSrc   = 1'b1;
          ExtOp    = 2'd1;
          lwl      = 1'b1;
          RegWrite = 1'b1;
        end
        OP_SW: begin
          ALUSrc   = 1'b1;
          ExtOp    = 2'd1;
          MemWrite = 1'b1;
        end
        OP_BEQ: begin
          Branch  = 1'b1;
          ALUCtrl = 3'b001;
          ExtOp   = 2'd1;
        end
        OP_J: Jump = 1'b1;
        OP_JAL: begin
          Jump     = 1'b1;
          Link     = 1'b1;
          RegDst   = 2'd2;
          RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
module tb_controller;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] func;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic [2:0] ALUCtrl;
  logic [1:0] ExtOp;
  logic       MemtoReg;
  logic       lwl;
  logic       RegWrite;
  logic       MemWrite;
  logic       Branch;
  logic       Jump;
  logic       JumpReg;
  logic       Link;

  controller dut (
    .clk(clk), .reset(reset), .Op(Op), .func(func),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .ExtOp(ExtOp),
    .MemtoReg(MemtoReg), .lwl(lwl), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .Link(Link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector: {RegDst[1:0], ALUSrc, ALUCtrl[2:0], ExtOp[1:0],
  //                  MemtoReg, lwl, RegWrite, MemWrite, Branch, Jump, JumpReg, Link}
  typedef struct {
    logic [15:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   model_en = 1'b0;

  function automatic string mnemonic(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn == 6'b100001) return "addu";
      if (fn == 6'b100011) return "subu";
      if (fn == 6'b001000) return "jr";
      return "undef";
    end
    case (op)
      6'b001101: return "ori";
      6'b001111: return "lui";
      6'b100011: return "lw";
      6'b100010: return "lwl";
      6'b101011: return "sw";
      6'b000100: return "beq";
      6'b000010: return "j";
      6'b000011: return "jal";
      default:   return "undef";
    endcase
  endfunction

  function automatic logic [15:0] ref_vec(input bit en, input string m);
    logic [1:0] rd = 0, ext = 0;
    logic [2:0] alu = 0;
    logic src = 0, m2r = 0, lw_l = 0, rw = 0, mw = 0, br = 0, jp = 0, jr = 0, lk = 0;
    if (en) begin
      if (m == "addu") begin rd = 1; alu = 0; rw = 1; end
      if (m == "subu") begin rd = 1; alu = 1; rw = 1; end
      if (m == "jr")   jr = 1;
      if (m == "ori")  begin src = 1; ext = 0; alu = 2; rw = 1; end
      if (m == "lui")  begin src = 1; ext = 2; alu = 3; rw = 1; end
      if (m == "lw")   begin src = 1; ext = 1; m2r = 1; rw = 1; end
      if (m == "lwl")  begin src = 1; ext = 1; lw_l = 1; rw = 1; end
      if (m == "sw")   begin src = 1; ext = 1; mw = 1; end
      if (m == "beq")  begin br = 1; alu = 1; ext = 1; end
      if (m == "j")    jp = 1;
      if (m == "jal")  begin jp = 1; lk = 1; rd = 2; rw = 1; end
    end
    return {rd, src, alu, ext, m2r, lw_l, rw, mw, br, jp, jr, lk};
  endfunction

  // One stimulus cycle: just after a rising edge, apply reset/Op/func and
  // queue what the outputs must show at the following falling edge.
  task automatic cycle(input logic rst_val, input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    @(posedge clk);
    if (reset) model_en = 1'b1;
    #2;
    reset = rst_val;
    if (!rst_val) model_en = 1'b0;
    Op   = op;
    func = fn;
    e.name = $sformatf("%s op=%b fn=%b en=%0d", mnemonic(op, fn), op, fn, model_en);
    e.vec  = ref_vec(model_en, mnemonic(op, fn));
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the edge that arms en.
  always @(negedge clk) begin
    logic [15:0] act;
    exp_t e;
    act = {RegDst, ALUSrc, ALUCtrl, ExtOp, MemtoReg, lwl, RegWrite, MemWrite,
           Branch, Jump, JumpReg, Link};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e.vec) begin
        n_fail++;
        $display("FAIL decode %s: got %b expected %b", e.name, act, e.vec);
      end
    end
    n_checks++;
    if ((MemtoReg && lwl) || (MemWrite && RegWrite) ||
        (int'(Jump) + int'(JumpReg) + int'(Branch) > 1)) begin
      n_fail++;
      $display("FAIL invariant: got %b expected no conflicting bits", act);
    end
  end

  initial begin
    reset = 1'b0;
    Op    = 6'b101011;
    func  = 6'd0;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got MemWrite=%b RegWrite=%b expected 0 0", MemWrite, RegWrite);
    end

    // sw held through reset; release between edges
    cycle(1'b0, 6'b101011, 6'd0);
    cycle(1'b1, 6'b101011, 6'd0);   // released, no edge yet: NOP
    cycle(1'b1, 6'b101011, 6'd0);   // armed: sw visible

    // directed instructions
    cycle(1'b1, 6'b100011, 6'd0);          // lw
    cycle(1'b1, 6'b100010, 6'd0);          // lwl
    cycle(1'b1, 6'b000000, 6'b100001);     // addu
    cycle(1'b1, 6'b000000, 6'b100011);     // subu
    cycle(1'b1, 6'b000000, 6'b001000);     // jr
    cycle(1'b1, 6'b001101, 6'd0);          // ori
    cycle(1'b1, 6'b001111, 6'd0);          // lui
    cycle(1'b1, 6'b000011, 6'd0);          // jal
    cycle(1'b1, 6'b000100, 6'd0);          // beq
    cycle(1'b1, 6'b000010, 6'd0);          // j

    // asynchronous pulse during sw
    cycle(1'b1, 6'b101011, 6'd0);
    cycle(1'b0, 6'b101011, 6'd0);
    cycle(1'b1, 6'b101011, 6'd0);
    cycle(1'b1, 6'b101011, 6'd0);

    // full sweeps
    for (int i = 0; i < 64; i++) cycle(1'b1, 6'(i), 6'($urandom));
    for (int i = 0; i < 64; i++) cycle(1'b1, 6'd0, 6'(i));

    // random traffic with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 1) == 0) ? 6'(mnemonic_pick($urandom_range(0, 8))) : 6'($urandom);
      cycle(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, op, 6'($urandom));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [5:0] mnemonic_pick(input int unsigned k);
    case (k)
      0: return 6'b001101;
      1: return 6'b001111;
      2: return 6'b100011;
      3: return 6'b100010;
      4: return 6'b101011;
      5: return 6'b000100;
      6: return 6'b000010;
      7: return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

endmodule
